alu_seq_unit: RTL and testbench

//  Parametrised MIPS-style ALU with a registered result, a 6-bit funct select,
//  and a multi-cycle unsigned multiplier writing HI/LO.

---
 rtl/alu_seq_unit.sv | 177 +++++++++++++++++
 tb/tb_alu_seq_unit.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// alu_seq_unit
//   MIPS-style ALU with a registered result and a multi-cycle unsigned
//   shift-add multiplier that writes HI/LO. Single-cycle ops (AND, OR, ADD,
//   SUB, SLT, SLL, MFHI, MFLO) complete one edge after start. MULTU runs for
//   WIDTH edges and updates HI/LO together on the last one.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous reset, active low
//   start     op request, sampled only while not busy
//   funct     6-bit operation select
//   src_a     operand A (rs), multiplicand for MULTU
//   src_b     operand B (rt), shifted by SLL, multiplier for MULTU
//   shamt     SLL shift amount
//   busy      high while MULTU iterates; start is ignored then
//   done      one-cycle completion pulse
//   result    registered result, held until the next single-cycle completion
//   zero      registered (result == 0)
//   overflow  signed overflow of ADD/SUB, 0 for all other ops
//   hi, lo    upper/lower halves of the last MULTU product
module alu_seq_unit #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    typedef enum logic {IDLE, MUL} state_t;

    state_t state, state_nxt;

    logic [SHW-1:0]   count;
    logic             last_iter;
    logic [WIDTH-1:0] mcand_p0;
    logic [WIDTH-1:0] acc_hi_p0;
    logic [WIDTH-1:0] acc_lo_p0;
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic signed [WIDTH-1:0] sum_s;
    logic signed [WIDTH-1:0] diff_s;
    logic                    add_ovf;
    logic                    sub_ovf;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_ovf;

    // Two's-complement overflow: operands agree in sign, result disagrees.
    function automatic logic signed_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    assign a_s     = src_a;
    assign b_s     = src_b;
    assign sum_s   = a_s + b_s;
    assign diff_s  = a_s - b_s;
    assign add_ovf = signed_ovf(a_s[WIDTH-1], b_s[WIDTH-1], sum_s[WIDTH-1]);
    assign sub_ovf = signed_ovf(a_s[WIDTH-1], ~b_s[WIDTH-1], diff_s[WIDTH-1]);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (funct)
            F_AND:  alu_res = src_a & src_b;
            F_OR:   alu_res = src_a | src_b;
            F_ADD:  begin alu_res = sum_s;  alu_ovf = add_ovf; end
            F_SUB:  begin alu_res = diff_s; alu_ovf = sub_ovf; end
            // The raw difference sign is wrong when the subtraction overflows.
            F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, diff_s[WIDTH-1] ^ sub_ovf};
            F_SLL:  alu_res = src_b << shamt;
            F_MFHI: alu_res = hi;
            F_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: conditionally add the multiplicand into the upper
    // half, then shift the whole {carry, hi, lo} right by one.
    assign step_sum           = {1'b0, acc_hi_p0} + (acc_lo_p0[0] ? {1'b0, mcand_p0} : '0);
    assign {step_hi, step_lo} = {step_sum, acc_lo_p0[WIDTH-1:1]};
    assign last_iter          = (count == SHW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && funct == F_MULTU) state_nxt = MUL;
            MUL:     if (last_iter) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == MUL);
    end

    // ---- stage p0: operand capture and multiplier accumulator ----
    always_ff @(posedge clk) begin
        if (state == IDLE && start && funct == F_MULTU) begin
            mcand_p0  <= src_a;
            acc_hi_p0 <= '0;
            acc_lo_p0 <= src_b;
        end else if (state == MUL) begin
            acc_hi_p0 <= step_hi;
            acc_lo_p0 <= step_lo;
        end
    end

    // ---- stage p1: architectural outputs and iteration counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            count    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (funct == F_MULTU) begin
                            count <= '0;
                        end else begin
                            result   <= alu_res;
                            zero     <= (alu_res == '0);
                            overflow <= alu_ovf;
                            done     <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    count <= count + SHW'(1);
                    if (last_iter) begin
                        hi    <= step_hi;
                        lo    <= step_lo;
                        done  <= 1'b1;
                        count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
module tb_alu_seq_unit;

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_BAD   = 6'b111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0;
    logic [5:0]  funct = 6'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic [4:0]  shamt = 5'd0;
    logic        busy, done, zero, overflow;
    logic [31:0] result, hi, lo;

    logic        start8 = 1'b0;
    logic [5:0]  funct8 = 6'd0;
    logic [7:0]  src_a8 = 8'd0;
    logic [7:0]  src_b8 = 8'd0;
    logic [2:0]  shamt8 = 3'd0;
    logic        busy8, done8, zero8, overflow8;
    logic [7:0]  result8, hi8, lo8;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    alu_seq_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
        .src_a(src_a), .src_b(src_b), .shamt(shamt),
        .busy(busy), .done(done), .result(result), .zero(zero),
        .overflow(overflow), .hi(hi), .lo(lo)
    );

    alu_seq_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .funct(funct8),
        .src_a(src_a8), .src_b(src_b8), .shamt(shamt8),
        .busy(busy8), .done(done8), .result(result8), .zero(zero8),
        .overflow(overflow8), .hi(hi8), .lo(lo8)
    );

    // Reference: results straight from the arithmetic definitions.
    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, output logic [31:0] r, output logic ov);
        longint s;
        r  = 32'd0;
        ov = 1'b0;
        case (f)
            F_AND:  r = a & b;
            F_OR:   r = a | b;
            F_ADD:  begin
                r  = a + b;
                s  = longint'($signed(a)) + longint'($signed(b));
                ov = (s != longint'($signed(r)));
            end
            F_SUB:  begin
                r  = a - b;
                s  = longint'($signed(a)) - longint'($signed(b));
                ov = (s != longint'($signed(r)));
            end
            F_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            F_SLL:  r = b << sh;
            F_MFHI: r = m_hi;
            F_MFLO: r = m_lo;
            default: r = 32'd0;
        endcase
    endfunction

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        @(negedge clk);
        start = 1'b1;
        funct = f;
        src_a = a;
        src_b = b;
        shamt = sh;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, zero, overflow} !== 4'b0 || result !== 32'd0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset32: busy=%b done=%b zero=%b ovf=%b result=%h hi=%h lo=%h, required all 0",
                     busy, done, zero, overflow, result, hi, lo);
        end
        checks++;
        if ({busy8, done8, zero8, overflow8} !== 4'b0 || result8 !== 8'd0 || hi8 !== 8'd0 || lo8 !== 8'd0) begin
            failures++;
            $display("FAIL reset8: busy=%b done=%b result=%h hi=%h lo=%h, required all 0",
                     busy8, done8, result8, hi8, lo8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_sub;
        issue(F_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd0);
        checks++;
        if (done !== 1'b1 || result !== 32'h80000000 || overflow !== 1'b1 || zero !== 1'b0) begin
            failures++;
            $display("FAIL add_ovf: done=%b result=%h ovf=%b zero=%b, required 1 80000000 1 0",
                     done, result, overflow, zero);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_single_pulse: done=%b, required 0", done);
        end
        issue(F_SUB, 32'd5, 32'd5, 5'd0);
        checks++;
        if (done !== 1'b1 || result !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL sub_zero: done=%b result=%h zero=%b ovf=%b, required 1 0 1 0",
                     done, result, zero, overflow);
        end
    endtask

    task automatic test_slt;
        issue(F_SLT, 32'h80000000, 32'h00000001, 5'd0);
        checks++;
        if (result !== 32'd1 || overflow !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL slt_neg: result=%h ovf=%b done=%b, required 1 0 1", result, overflow, done);
        end
        issue(F_SLT, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0);
        checks++;
        if (result !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL slt_pos: result=%h zero=%b ovf=%b, required 0 1 0", result, zero, overflow);
        end
    endtask

    task automatic test_sll;
        issue(F_SLL, 32'h0, 32'h0000000F, 5'd28);
        checks++;
        if (result !== 32'hF0000000) begin
            failures++;
            $display("FAIL sll_28: result=%h, required f0000000", result);
        end
        issue(F_SLL, 32'h0, 32'h00000003, 5'd31);
        checks++;
        if (result !== 32'h80000000) begin
            failures++;
            $display("FAIL sll_31: result=%h, required 80000000", result);
        end
        issue(F_SLL, 32'h0, 32'h12345678, 5'd0);
        checks++;
        if (result !== 32'h12345678) begin
            failures++;
            $display("FAIL sll_0: result=%h, required 12345678", result);
        end
    endtask

    task automatic test_multu;
        int n;
        logic [31:0] held;
        issue(F_ADD, 32'd40, 32'd2, 5'd0);
        held = result;
        issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL multu_busy: busy=%b done=%b, required 1 0", busy, done);
        end
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            if (n == 5) begin
                start = 1'b1;
                funct = F_ADD;
            end
            if (n == 6) start = 1'b0;
            src_a = $urandom;
            src_b = $urandom;
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1 && busy === 1'b1) begin
                checks++;
                failures++;
                $display("FAIL busy_done_overlap: busy=%b done=%b, required not both 1", busy, done);
            end
        end
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL multu_latency: cycles=%0d, required 32", n);
        end
        checks++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001 || result !== held) begin
            failures++;
            $display("FAIL multu_max: hi=%h lo=%h result=%h, required fffffffe 00000001 %h",
                     hi, lo, result, held);
        end
        m_hi = 32'hFFFFFFFE;
        m_lo = 32'h00000001;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL multu_after: done=%b busy=%b, required 0 0", done, busy);
        end
        issue(F_MFHI, 32'd0, 32'd0, 5'd0);
        checks++;
        if (result !== 32'hFFFFFFFE || done !== 1'b1) begin
            failures++;
            $display("FAIL mfhi: result=%h done=%b, required fffffffe 1", result, done);
        end
        issue(F_MFLO, 32'd0, 32'd0, 5'd0);
        checks++;
        if (result !== 32'h00000001 || zero !== 1'b0) begin
            failures++;
            $display("FAIL mflo: result=%h zero=%b, required 00000001 0", result, zero);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        start = 1'b1;
        funct = F_ADD;
        src_a = 32'd1;
        src_b = 32'd2;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || result !== 32'd3) begin
            failures++;
            $display("FAIL b2b_first: done=%b result=%h, required 1 3", done, result);
        end
        funct = F_SUB;
        src_a = 32'd10;
        src_b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || result !== 32'd7) begin
            failures++;
            $display("FAIL b2b_second: done=%b result=%h, required 1 7", done, result);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: done=%b, required 0", done);
        end
    endtask

    task automatic test_width8;
        int n;
        @(negedge clk);
        start8 = 1'b1;
        funct8 = F_MULTU;
        src_a8 = 8'hC8;
        src_b8 = 8'h03;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        n = 0;
        while (done8 !== 1'b1 && n < 40) begin
            src_a8 = 8'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 8 || hi8 !== 8'h02 || lo8 !== 8'h58) begin
            failures++;
            $display("FAIL multu8: cycles=%0d hi=%h lo=%h, required 8 02 58", n, hi8, lo8);
        end
        // Start an AND in the done cycle.
        start8 = 1'b1;
        funct8 = F_AND;
        src_a8 = 8'hF0;
        src_b8 = 8'h3C;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        checks++;
        if (done8 !== 1'b1 || result8 !== 8'h30 || busy8 !== 1'b0) begin
            failures++;
            $display("FAIL and8_b2b: done=%b result=%h busy=%b, required 1 30 0", done8, result8, busy8);
        end
    endtask

    task automatic test_random;
        logic [5:0]  pool [10] = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_MULTU, F_MFHI, F_MFLO, F_BAD};
        logic [5:0]  f;
        logic [31:0] a, b, r, held;
        logic [4:0]  sh;
        logic        ov;
        logic [63:0] p;
        int n;
        for (int i = 0; i < 40; i++) begin
            f  = pool[$urandom_range(9, 0)];
            a  = $urandom;
            b  = $urandom;
            sh = 5'($urandom);
            if ($urandom_range(3, 0) == 0) b = a;
            if (f == F_MULTU) begin
                held = result;
                p = {32'd0, a} * {32'd0, b};
                issue(f, a, b, sh);
                n = 0;
                while (done !== 1'b1 && n < 100) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                checks++;
                if (n != 32 || hi !== p[63:32] || lo !== p[31:0] || result !== held) begin
                    failures++;
                    $display("FAIL rand_multu %h*%h: cycles=%0d hi=%h lo=%h result=%h, required 32 %h %h %h",
                             a, b, n, hi, lo, result, p[63:32], p[31:0], held);
                end
                m_hi = p[63:32];
                m_lo = p[31:0];
            end else begin
                model(f, a, b, sh, r, ov);
                issue(f, a, b, sh);
                checks++;
                if (done !== 1'b1 || result !== r || zero !== (r == 32'd0) || overflow !== ov) begin
                    failures++;
                    $display("FAIL rand_op f=%b a=%h b=%h sh=%0d: done=%b result=%h zero=%b ovf=%b, required 1 %h %b %b",
                             f, a, b, sh, done, result, zero, overflow, r, (r == 32'd0), ov);
                end
            end
        end
    endtask

    task automatic test_unknown;
        issue(F_ADD, 32'h80000000, 32'h80000000, 5'd0);
        issue(F_BAD, 32'h12345678, 32'h9ABCDEF0, 5'd3);
        checks++;
        if (done !== 1'b1 || result !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL unknown_funct: done=%b result=%h zero=%b ovf=%b, required 1 0 1 0",
                     done, result, zero, overflow);
        end
    endtask

    task automatic test_reset_mid_mul;
        int seen;
        issue(F_ADD, 32'd9, 32'd9, 5'd0);
        issue(F_MULTU, 32'hDEADBEEF, 32'h12345678, 5'd0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, zero, overflow} !== 4'b0 || result !== 32'd0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_mul: busy=%b done=%b zero=%b ovf=%b result=%h hi=%h lo=%h, required all 0",
                     busy, done, zero, overflow, result, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL no_done_after_abort: active cycles=%0d, required 0", seen);
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_slt();
        test_sll();
        test_multu();
        test_back_to_back();
        test_width8();
        test_random();
        test_unknown();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
